// File: rtl/mul2x2_stream_driver_pkg.sv
// Shared defaults, issue-state encoding and output-word layout for the 2x2 multiplier stream driver.
package mul_stream_pkg;

    localparam int MUL_DATA_W   = 2;
    localparam int MUL_RES_W    = 4;
    localparam int OUT_PROD_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_CREDIT
    } issue_state_t;

    // Output word is {a, b, product}; product occupies the LSBs.
    function automatic int out_b_lsb(input int res_w);
        return OUT_PROD_LSB + res_w;
    endfunction

    function automatic int out_a_lsb(input int data_w, input int res_w);
        return out_b_lsb(res_w) + data_w;
    endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Synchronous FIFO with a registered-storage head word, occupancy count and full/empty flags.
module stream_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul2x2_stream_driver.sv
// Splits operand pairs onto A/B streams, pairs returning products in order as {a,b,product}.
// Optional product self-check enabled by defining MUL_DRV_CHECK_EN (adds check_err, err_cnt).
module mul2x2_stream_driver
    import mul_stream_pkg::*;
#(
    parameter int DATA_W    = MUL_DATA_W,
    parameter int RES_W     = MUL_RES_W,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*DATA_W-1:0]       s_op_tdata,
    input  logic                      s_op_tvalid,
    output logic                      s_op_tready,
    output logic [DATA_W-1:0]         m_a_tdata,
    output logic                      m_a_tvalid,
    input  logic                      m_a_tready,
    output logic [DATA_W-1:0]         m_b_tdata,
    output logic                      m_b_tvalid,
    input  logic                      m_b_tready,
    input  logic [RES_W-1:0]          s_res_tdata,
    input  logic                      s_res_tvalid,
    output logic                      s_res_tready,
    output logic [2*DATA_W+RES_W-1:0] m_out_tdata,
    output logic                      m_out_tvalid,
    input  logic                      m_out_tready,
    output logic                      busy,
    output logic                      timeout_err
`ifdef MUL_DRV_CHECK_EN
    ,
    output logic                      check_err,
    output logic [7:0]                err_cnt
`endif
);

    localparam int CW     = $clog2(DEPTH) + 1;
    localparam int OUT_W  = 2*DATA_W + RES_W;
    localparam int B_LSB  = out_b_lsb(RES_W);
    localparam int A_LSB  = out_a_lsb(DATA_W, RES_W);

    issue_state_t          state;
    logic                  a_sent, b_sent;
    logic [2*DATA_W-1:0]   issue_head, inflight_head;
    logic                  issue_full, issue_empty, inflight_full, inflight_empty;
    logic [CW-1:0]         issue_count, inflight_count;
    logic                  op_push, a_xfer, b_xfer, pair_done, res_xfer;
    logic                  next_avail, credit_next;
    logic [TIMEOUT_W-1:0]  wdog;
    logic [OUT_W-1:0]      out_word;

    assign s_op_tready  = !issue_full;
    assign op_push      = s_op_tvalid && s_op_tready;
    // Operand data comes straight from the FIFO head, which cannot change until the pair completes.
    assign m_a_tdata    = issue_head[2*DATA_W-1:DATA_W];
    assign m_b_tdata    = issue_head[DATA_W-1:0];
    assign a_xfer       = m_a_tvalid && m_a_tready;
    assign b_xfer       = m_b_tvalid && m_b_tready;
    assign pair_done    = (state == ISSUE) && (a_sent || a_xfer) && (b_sent || b_xfer);
    assign s_res_tready = !inflight_empty && (!m_out_tvalid || m_out_tready);
    assign res_xfer     = s_res_tvalid && s_res_tready;
    assign next_avail   = (issue_count >= CW'(2)) || op_push;
    assign credit_next  = res_xfer || (inflight_count < CW'(DEPTH-1));
    assign busy         = !issue_empty || !inflight_empty || m_out_tvalid;

    always_comb begin
        out_word = '0;
        out_word[A_LSB +: DATA_W]        = inflight_head[2*DATA_W-1:DATA_W];
        out_word[B_LSB +: DATA_W]        = inflight_head[DATA_W-1:0];
        out_word[OUT_PROD_LSB +: RES_W]  = s_res_tdata;
    end

    stream_sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) u_issue_fifo (
        .clk(clk), .rst(rst),
        .push(op_push), .push_data(s_op_tdata),
        .pop(pair_done), .head(issue_head),
        .full(issue_full), .empty(issue_empty), .count(issue_count)
    );

    stream_sync_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) u_inflight_fifo (
        .clk(clk), .rst(rst),
        .push(pair_done), .push_data(issue_head),
        .pop(res_xfer), .head(inflight_head),
        .full(inflight_full), .empty(inflight_empty), .count(inflight_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sent     <= 1'b0;
            b_sent     <= 1'b0;
            m_a_tvalid <= 1'b0;
            m_b_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!issue_empty && !inflight_full) begin
                        state      <= ISSUE;
                        m_a_tvalid <= 1'b1;
                        m_b_tvalid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (pair_done) begin
                        a_sent <= 1'b0;
                        b_sent <= 1'b0;
                        if (next_avail && credit_next) begin
                            m_a_tvalid <= 1'b1;
                            m_b_tvalid <= 1'b1;
                        end else begin
                            state      <= next_avail ? WAIT_CREDIT : IDLE;
                            m_a_tvalid <= 1'b0;
                            m_b_tvalid <= 1'b0;
                        end
                    end else begin
                        if (a_xfer) begin
                            a_sent     <= 1'b1;
                            m_a_tvalid <= 1'b0;
                        end
                        if (b_xfer) begin
                            b_sent     <= 1'b1;
                            m_b_tvalid <= 1'b0;
                        end
                    end
                end
                WAIT_CREDIT: begin
                    if (!inflight_full) begin
                        state      <= ISSUE;
                        m_a_tvalid <= 1'b1;
                        m_b_tvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_out_tdata  <= '0;
            m_out_tvalid <= 1'b0;
        end else if (res_xfer) begin
            m_out_tdata  <= out_word;
            m_out_tvalid <= 1'b1;
        end else if (m_out_tready) begin
            m_out_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (res_xfer || inflight_empty) begin
                wdog <= '0;
            end else if (wdog != '1) begin
                wdog <= wdog + 1'b1;
            end
            if (wdog == '1) begin
                timeout_err <= 1'b1;
            end
        end
    end

`ifdef MUL_DRV_CHECK_EN
    logic [RES_W-1:0] exp_prod;

    assign exp_prod = RES_W'(inflight_head[2*DATA_W-1:DATA_W]) * RES_W'(inflight_head[DATA_W-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            check_err <= 1'b0;
            err_cnt   <= '0;
        end else if (res_xfer && (s_res_tdata != exp_prod)) begin
            check_err <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul2x2_stream_driver.sv
// Directed self-checking bench for mul2x2_stream_driver (DATA_W=2, RES_W=4, DEPTH=4).
module tb_mul2x2_stream_driver;

    logic       clk;
    logic       rst;
    logic [3:0] s_op_tdata;
    logic       s_op_tvalid;
    logic       s_op_tready;
    logic [1:0] m_a_tdata;
    logic       m_a_tvalid;
    logic       m_a_tready;
    logic [1:0] m_b_tdata;
    logic       m_b_tvalid;
    logic       m_b_tready;
    logic [3:0] s_res_tdata;
    logic       s_res_tvalid;
    logic       s_res_tready;
    logic [7:0] m_out_tdata;
    logic       m_out_tvalid;
    logic       m_out_tready;
    logic       busy;
    logic       timeout_err;
`ifdef MUL_DRV_CHECK_EN
    logic       check_err;
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mul2x2_stream_driver #(.DATA_W(2), .RES_W(4), .DEPTH(4), .TIMEOUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_op_tdata(s_op_tdata), .s_op_tvalid(s_op_tvalid), .s_op_tready(s_op_tready),
        .m_a_tdata(m_a_tdata), .m_a_tvalid(m_a_tvalid), .m_a_tready(m_a_tready),
        .m_b_tdata(m_b_tdata), .m_b_tvalid(m_b_tvalid), .m_b_tready(m_b_tready),
        .s_res_tdata(s_res_tdata), .s_res_tvalid(s_res_tvalid), .s_res_tready(s_res_tready),
        .m_out_tdata(m_out_tdata), .m_out_tvalid(m_out_tvalid), .m_out_tready(m_out_tready),
        .busy(busy), .timeout_err(timeout_err)
`ifdef MUL_DRV_CHECK_EN
        , .check_err(check_err), .err_cnt(err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_out [4];
        logic [3:0] prod    [4];
        logic [3:0] pairs   [8];
        int issued;
        int accepted;

        exp_out[0] = 8'hF9; exp_out[1] = 8'h92; exp_out[2] = 8'h51; exp_out[3] = 8'hE6;
        prod[0] = 4'd9; prod[1] = 4'd2; prod[2] = 4'd1; prod[3] = 4'd6;
        pairs[0] = 4'b11_11; pairs[1] = 4'b10_01; pairs[2] = 4'b01_01; pairs[3] = 4'b11_10;
        pairs[4] = 4'b00_11; pairs[5] = 4'b10_10; pairs[6] = 4'b01_11; pairs[7] = 4'b11_00;

        rst = 1'b1;
        s_op_tdata = '0; s_op_tvalid = 1'b0;
        m_a_tready = 1'b0; m_b_tready = 1'b0;
        s_res_tdata = '0; s_res_tvalid = 1'b0;
        m_out_tready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_s_op_tready", 32'(s_op_tready), 1);
        check("rst_s_res_tready", 32'(s_res_tready), 0);
        check("rst_m_a_tvalid", 32'(m_a_tvalid), 0);
        check("rst_m_b_tvalid", 32'(m_b_tvalid), 0);
        check("rst_m_out_tvalid", 32'(m_out_tvalid), 0);
        check("rst_m_out_tdata", 32'(m_out_tdata), 0);
        check("rst_m_a_tdata", 32'(m_a_tdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);

        // Single pair {3,2} -> product 6
        m_a_tready = 1'b1; m_b_tready = 1'b1;
        s_op_tdata = 4'b11_10; s_op_tvalid = 1'b1;
        tick();
        s_op_tvalid = 1'b0;
        check("t1_not_yet_valid", 32'(m_a_tvalid), 0);
        tick();
        check("t1_a_valid", 32'(m_a_tvalid), 1);
        check("t1_b_valid", 32'(m_b_tvalid), 1);
        check("t1_a_data", 32'(m_a_tdata), 3);
        check("t1_b_data", 32'(m_b_tdata), 2);
        check("t1_busy", 32'(busy), 1);
        tick();
        check("t1_a_dropped", 32'(m_a_tvalid), 0);
        check("t1_b_dropped", 32'(m_b_tvalid), 0);
        check("t1_res_ready", 32'(s_res_tready), 1);
        s_res_tdata = 4'd6; s_res_tvalid = 1'b1;
        tick();
        s_res_tvalid = 1'b0;
        check("t1_out_valid", 32'(m_out_tvalid), 1);
        check("t1_out_data", 32'(m_out_tdata), 32'hE6);
`ifdef MUL_DRV_CHECK_EN
        check("t1_no_check_err", 32'(check_err), 0);
`endif
        tick();
        check("t1_out_drop", 32'(m_out_tvalid), 0);
        check("t1_idle", 32'(busy), 0);

        // A ready, B stalled for 3 cycles
        m_a_tready = 1'b1; m_b_tready = 1'b0;
        s_op_tdata = 4'b01_11; s_op_tvalid = 1'b1;
        tick();
        s_op_tvalid = 1'b0;
        tick();
        check("t2_both_valid", 32'({m_a_tvalid, m_b_tvalid}), 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_a_dropped", 32'(m_a_tvalid), 0);
            check("t2_b_held", 32'(m_b_tvalid), 1);
            check("t2_b_data", 32'(m_b_tdata), 3);
            check("t2_no_pop", 32'(s_res_tready), 0);
        end
        m_b_tready = 1'b1;
        tick();
        check("t2_b_dropped", 32'(m_b_tvalid), 0);
        check("t2_inflight", 32'(s_res_tready), 1);
        s_res_tdata = 4'd3; s_res_tvalid = 1'b1;
        tick();
        s_res_tvalid = 1'b0;
        check("t2_out_data", 32'(m_out_tdata), 32'h73);
        tick();

        // Eight pushes, no results: only DEPTH issued, issue FIFO fills
        issued = 0; accepted = 0;
        for (int i = 0; i < 8; i++) begin
            s_op_tdata = pairs[i]; s_op_tvalid = 1'b1;
            if (s_op_tready) accepted++;
            if (m_a_tvalid && m_b_tvalid) issued++;
            tick();
        end
        s_op_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_a_tvalid && m_b_tvalid) issued++;
            tick();
        end
        check("t3_accepted", 32'(accepted), 8);
        check("t3_issued", 32'(issued), 4);
        check("t3_issue_full", 32'(s_op_tready), 0);
        check("t3_wait_credit", 32'({m_a_tvalid, m_b_tvalid}), 0);
        check("t3_busy", 32'(busy), 1);

        // Output backpressure, then 4 back-to-back outputs
        m_a_tready = 1'b0; m_b_tready = 1'b0;
        m_out_tready = 1'b0;
        s_res_tdata = prod[0]; s_res_tvalid = 1'b1;
        check("t4_res_ready_pre", 32'(s_res_tready), 1);
        tick();
        s_res_tdata = prod[1];
        check("t4_stalled_ready", 32'(s_res_tready), 0);
        tick();
        tick();
        check("t4_still_stalled", 32'(s_res_tready), 0);
        check("t4_held_data", 32'(m_out_tdata), 32'(exp_out[0]));
        m_out_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t4_out_valid", 32'(m_out_tvalid), 1);
            check("t4_out_data", 32'(m_out_tdata), 32'(exp_out[k]));
            tick();
            if (k + 2 < 4) s_res_tdata = prod[k+2];
            else s_res_tvalid = 1'b0;
        end
        check("t4_out_drained", 32'(m_out_tvalid), 0);

        // Watchdog: one pair in flight, never answered
        m_a_tready = 1'b1; m_b_tready = 1'b1;
        tick();
        m_a_tready = 1'b0; m_b_tready = 1'b0;
        check("t5_inflight", 32'(s_res_tready), 1);
        repeat (100) tick();
        check("t5_no_early_timeout", 32'(timeout_err), 0);
        for (int i = 0; i < 300 && !timeout_err; i++) tick();
        check("t5_timeout_set", 32'(timeout_err), 1);
        repeat (5) tick();
        check("t5_timeout_sticky", 32'(timeout_err), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_rst_clears", 32'(timeout_err), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_op_ready", 32'(s_op_tready), 1);
        check("t5_rst_a_valid", 32'(m_a_tvalid), 0);

        // Wrong product {2,2} -> 5 passes through unchanged
        m_a_tready = 1'b1; m_b_tready = 1'b1; m_out_tready = 1'b1;
        s_op_tdata = 4'b10_10; s_op_tvalid = 1'b1;
        tick();
        s_op_tvalid = 1'b0;
        tick();
        tick();
        s_res_tdata = 4'd5; s_res_tvalid = 1'b1;
        tick();
        s_res_tvalid = 1'b0;
        check("t6_out_data", 32'(m_out_tdata), 32'hA5);
`ifdef MUL_DRV_CHECK_EN
        check("t6_check_err", 32'(check_err), 1);
        check("t6_err_cnt", 32'(err_cnt), 1);
`endif
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
